// File: rtl/vdp_pkg.sv
// Shared encodings for the VDP port front-end: command codes, prefetch
// FSM states, internal port events and status-byte bit positions.
package vdp_pkg;

  // Two-bit code register values written by the second control byte
  typedef enum logic [1:0] {
    CODE_VRD  = 2'd0,
    CODE_VWR  = 2'd1,
    CODE_REG  = 2'd2,
    CODE_CRAM = 2'd3
  } code_e;

  // VRAM read-ahead sequencer
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LATCH = 2'd2
  } pf_state_e;

  // Port events after edge detection; also the content of the pending slot
  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_CTRL_WR = 3'd1,
    EV_DATA_WR = 3'd2,
    EV_DATA_RD = 3'd3,
    EV_CTRL_RD = 3'd4
  } event_e;

  // Status byte bit positions
  localparam int STAT_F   = 7;
  localparam int STAT_OVR = 6;
  localparam int STAT_COL = 5;

endpackage

// File: rtl/vdp_io_port_strobe_edge.sv
// Registered edge detector for one mmu level strobe. The strobe is sampled
// into a flop and compared with its previous sample, so the single-cycle
// pulse comes purely from registers.
module strobe_edge #(
  parameter bit FALLING = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic pulse
);

  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values: capture the strobe, then shift it into the history flop
  always_comb begin
    sync_d = strobe;
    prev_d = sync_q;
  end

  // Sample history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign pulse = FALLING ? (prev_q & ~sync_q) : (sync_q & ~prev_q);

endmodule

// File: rtl/vdp_io_port.sv
// Z80-facing VDP port front-end: control latch, auto-incrementing address,
// code register, VRAM read-ahead buffer, Game Gear CRAM byte-pair latch,
// status flags and the frame interrupt line.
module vdp_io_port
  import vdp_pkg::*;
#(
  parameter int VRAM_AW = 14,
  parameter int CRAM_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               control_wr,
  input  logic               control_rd,
  input  logic [7:0]         control_i,
  output logic [7:0]         control_o,
  input  logic               data_wr,
  input  logic               data_rd,
  input  logic [7:0]         data_i,
  output logic [7:0]         data_o,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [11:0]        cram_wdata,
  output logic               reg_we,
  output logic [3:0]         reg_addr,
  output logic [7:0]         reg_data,
  input  logic               vblank_set,
  input  logic               spr_ovr_set,
  input  logic               spr_col_set,
  input  logic               frame_ie,
  output logic               irq_n
);

  localparam logic [VRAM_AW-1:0] ADDR_ONE = VRAM_AW'(1);

  logic cw_ev, dw_ev, dr_ev, cr_ev;

  strobe_edge #(.FALLING(1'b0)) u_cw_edge (.clk(clk), .rst(rst), .strobe(control_wr), .pulse(cw_ev));
  strobe_edge #(.FALLING(1'b0)) u_dw_edge (.clk(clk), .rst(rst), .strobe(data_wr),    .pulse(dw_ev));
  strobe_edge #(.FALLING(1'b1)) u_dr_edge (.clk(clk), .rst(rst), .strobe(data_rd),    .pulse(dr_ev));
  strobe_edge #(.FALLING(1'b1)) u_cr_edge (.clk(clk), .rst(rst), .strobe(control_rd), .pulse(cr_ev));

  pf_state_e          state_q, state_d;
  event_e             pend_ev_q, pend_ev_d;
  logic [7:0]         pend_data_q, pend_data_d;
  logic               second_q, second_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  code_e              code_q, code_d;
  logic [7:0]         buffer_q, buffer_d;
  logic [7:0]         cram_latch_q, cram_latch_d;
  logic               f_q, f_d, ovr_q, ovr_d, col_q, col_d;
  logic               irq_n_q, irq_n_d;
  logic               vram_we_q, vram_we_d;
  logic [VRAM_AW-1:0] vram_waddr_q, vram_waddr_d;
  logic [7:0]         vram_wdata_q, vram_wdata_d;
  logic               cram_we_q, cram_we_d;
  logic [CRAM_AW-1:0] cram_addr_q, cram_addr_d;
  logic [11:0]        cram_wdata_q, cram_wdata_d;
  logic               reg_we_q, reg_we_d;
  logic [3:0]         reg_addr_q, reg_addr_d;
  logic [7:0]         reg_data_q, reg_data_d;

  event_e     new_ev, exec_ev;
  logic [7:0] new_data, exec_data;
  logic       clear_flags;

  // Pick this cycle's fresh port event and capture its write data
  always_comb begin
    new_ev   = EV_NONE;
    new_data = 8'h00;
    if (cw_ev) begin
      new_ev   = EV_CTRL_WR;
      new_data = control_i;
    end else if (dw_ev) begin
      new_ev   = EV_DATA_WR;
      new_data = data_i;
    end else if (dr_ev) begin
      new_ev   = EV_DATA_RD;
    end else if (cr_ev) begin
      new_ev   = EV_CTRL_RD;
    end
  end

  // Prefetch sequencing, pending-event arbitration and port command decode
  always_comb begin
    state_d      = state_q;
    pend_ev_d    = pend_ev_q;
    pend_data_d  = pend_data_q;
    second_d     = second_q;
    addr_d       = addr_q;
    code_d       = code_q;
    buffer_d     = buffer_q;
    cram_latch_d = cram_latch_q;
    vram_we_d    = 1'b0;
    vram_waddr_d = vram_waddr_q;
    vram_wdata_d = vram_wdata_q;
    cram_we_d    = 1'b0;
    cram_addr_d  = cram_addr_q;
    cram_wdata_d = cram_wdata_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_data_d   = reg_data_q;
    clear_flags  = 1'b0;
    exec_ev      = EV_NONE;
    exec_data    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (pend_ev_q != EV_NONE) begin
          exec_ev     = pend_ev_q;
          exec_data   = pend_data_q;
          pend_ev_d   = new_ev;
          pend_data_d = new_data;
        end else begin
          exec_ev   = new_ev;
          exec_data = new_data;
        end
      end
      ST_FETCH: begin
        state_d = ST_LATCH;
        if (pend_ev_q == EV_NONE) begin
          pend_ev_d   = new_ev;
          pend_data_d = new_data;
        end
      end
      ST_LATCH: begin
        buffer_d = vram_rdata;
        addr_d   = addr_q + ADDR_ONE;
        state_d  = ST_IDLE;
        if (pend_ev_q == EV_NONE) begin
          pend_ev_d   = new_ev;
          pend_data_d = new_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (exec_ev)
      EV_CTRL_WR: begin
        if (!second_q) begin
          addr_d[7:0] = exec_data;
          second_d    = 1'b1;
        end else begin
          addr_d[VRAM_AW-1:8] = exec_data[VRAM_AW-9:0];
          code_d              = code_e'(exec_data[7:6]);
          second_d            = 1'b0;
          if (code_e'(exec_data[7:6]) == CODE_VRD) begin
            state_d = ST_FETCH;
          end else if (code_e'(exec_data[7:6]) == CODE_REG) begin
            reg_we_d   = 1'b1;
            reg_addr_d = exec_data[3:0];
            reg_data_d = addr_q[7:0];
          end
        end
      end
      EV_DATA_WR: begin
        second_d = 1'b0;
        buffer_d = exec_data;
        if (code_q == CODE_CRAM) begin
          if (!addr_q[0]) begin
            cram_latch_d = exec_data;
          end else begin
            cram_we_d    = 1'b1;
            cram_addr_d  = addr_q[CRAM_AW:1];
            cram_wdata_d = {exec_data[3:0], cram_latch_q};
          end
        end else begin
          vram_we_d    = 1'b1;
          vram_waddr_d = addr_q;
          vram_wdata_d = exec_data;
        end
        addr_d = addr_q + ADDR_ONE;
      end
      EV_DATA_RD: begin
        second_d = 1'b0;
        state_d  = ST_FETCH;
      end
      EV_CTRL_RD: begin
        second_d    = 1'b0;
        clear_flags = 1'b1;
      end
      default: ;
    endcase

    // A set pulse in the same cycle as the read-clear must survive
    f_d     = (f_q   & ~clear_flags) | vblank_set;
    ovr_d   = (ovr_q & ~clear_flags) | spr_ovr_set;
    col_d   = (col_q & ~clear_flags) | spr_col_set;
    irq_n_d = ~(f_q & frame_ie);
  end

  // State registers; reset aborts any prefetch and kills every write pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pend_ev_q    <= EV_NONE;
      pend_data_q  <= 8'h00;
      second_q     <= 1'b0;
      addr_q       <= '0;
      code_q       <= CODE_VRD;
      buffer_q     <= 8'h00;
      cram_latch_q <= 8'h00;
      f_q          <= 1'b0;
      ovr_q        <= 1'b0;
      col_q        <= 1'b0;
      irq_n_q      <= 1'b1;
      vram_we_q    <= 1'b0;
      vram_waddr_q <= '0;
      vram_wdata_q <= 8'h00;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= '0;
      cram_wdata_q <= 12'h000;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= 4'h0;
      reg_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      pend_ev_q    <= pend_ev_d;
      pend_data_q  <= pend_data_d;
      second_q     <= second_d;
      addr_q       <= addr_d;
      code_q       <= code_d;
      buffer_q     <= buffer_d;
      cram_latch_q <= cram_latch_d;
      f_q          <= f_d;
      ovr_q        <= ovr_d;
      col_q        <= col_d;
      irq_n_q      <= irq_n_d;
      vram_we_q    <= vram_we_d;
      vram_waddr_q <= vram_waddr_d;
      vram_wdata_q <= vram_wdata_d;
      cram_we_q    <= cram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_wdata_q <= cram_wdata_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_data_q   <= reg_data_d;
    end
  end

  assign control_o  = {f_q, ovr_q, col_q, 5'b00000};
  assign data_o     = buffer_q;
  assign vram_addr  = vram_we_q ? vram_waddr_q : addr_q;
  assign vram_we    = vram_we_q;
  assign vram_wdata = vram_wdata_q;
  assign cram_we    = cram_we_q;
  assign cram_addr  = cram_addr_q;
  assign cram_wdata = cram_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_data   = reg_data_q;
  assign irq_n      = irq_n_q;

endmodule

// File: tb/tb_vdp_io_port.sv
// Bench for the VDP port front-end. A transaction-level model of the port
// (address, code, buffer, latch, flags and a private copy of VRAM) predicts
// every write pulse and every read value; a simple synchronous VRAM model
// sits on the DUT memory interface.
module tb_vdp_io_port;

  localparam int OP_CW = 0;
  localparam int OP_DW = 1;
  localparam int OP_DR = 2;
  localparam int OP_CR = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        control_wr, control_rd, data_wr, data_rd;
  logic [7:0]  control_i, data_i;
  logic [7:0]  control_o, data_o;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic [7:0]  vram_rdata;
  logic        cram_we;
  logic [4:0]  cram_addr;
  logic [11:0] cram_wdata;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_data;
  logic        vblank_set, spr_ovr_set, spr_col_set, frame_ie;
  logic        irq_n;

  int testCount = 0;
  int failCount = 0;

  // Free-running 100 MHz-style clock
  always #5 clk = ~clk;

  vdp_io_port dut (
    .clk(clk), .rst(rst),
    .control_wr(control_wr), .control_rd(control_rd),
    .control_i(control_i), .control_o(control_o),
    .data_wr(data_wr), .data_rd(data_rd),
    .data_i(data_i), .data_o(data_o),
    .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .cram_we(cram_we), .cram_addr(cram_addr), .cram_wdata(cram_wdata),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .vblank_set(vblank_set), .spr_ovr_set(spr_ovr_set),
    .spr_col_set(spr_col_set), .frame_ie(frame_ie),
    .irq_n(irq_n)
  );

  // Physical VRAM seen by the DUT and the model's private copy of it
  logic [7:0] vram [0:16383];
  logic [7:0] refMem [0:16383];

  // Synchronous VRAM: read data appears one clock after the address
  always @(posedge clk) begin
    vram_rdata <= vram[vram_addr];
    if (vram_we) vram[vram_addr] = vram_wdata;
  end

  // Observed and predicted write pulses
  logic [21:0] obsVram[$], expVram[$];
  logic [16:0] obsCram[$], expCram[$];
  logic [11:0] obsReg[$],  expReg[$];

  // Record every write pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (vram_we) obsVram.push_back({vram_addr, vram_wdata});
    if (cram_we) obsCram.push_back({cram_addr, cram_wdata});
    if (reg_we)  obsReg.push_back({reg_addr, reg_data});
  end

  // Reference model state
  logic [13:0] mAddr;
  logic [1:0]  mCode;
  bit          mSecond;
  logic [7:0]  mBuffer, mLatch;
  bit          mF, mOvr, mCol;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mAddr = 14'h0000; mCode = 2'd0; mSecond = 1'b0;
    mBuffer = 8'h00; mLatch = 8'h00;
    mF = 1'b0; mOvr = 1'b0; mCol = 1'b0;
  endtask

  task automatic modelPrefetch();
    mBuffer = refMem[mAddr];
    mAddr   = mAddr + 14'd1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // One complete Z80 I/O cycle: strobe high for three clocks, then gap clocks idle
  task automatic applyStimulus(input int op, input logic [7:0] value, input int gap);
    @(posedge clk); #1;
    case (op)
      OP_CW: begin control_i = value; control_wr = 1'b1; end
      OP_DW: begin data_i = value; data_wr = 1'b1; end
      OP_DR: data_rd = 1'b1;
      default: control_rd = 1'b1;
    endcase
    repeat (2) @(posedge clk);
    @(negedge clk);
    if (op == OP_DR) checkOutput("data_read", data_o, mBuffer);
    if (op == OP_CR) checkOutput("status_read", control_o, {mF, mOvr, mCol, 5'b00000});
    @(posedge clk); #1;
    control_wr = 1'b0; control_rd = 1'b0; data_wr = 1'b0; data_rd = 1'b0;
    case (op)
      OP_CW: begin
        if (!mSecond) begin
          mAddr[7:0] = value;
          mSecond = 1'b1;
        end else begin
          mAddr[13:8] = value[5:0];
          mCode = value[7:6];
          mSecond = 1'b0;
          if (mCode == 2'd0) modelPrefetch();
          if (mCode == 2'd2) expReg.push_back({value[3:0], mAddr[7:0]});
        end
      end
      OP_DW: begin
        mSecond = 1'b0;
        mBuffer = value;
        if (mCode == 2'd3) begin
          if (mAddr[0] == 1'b0) mLatch = value;
          else expCram.push_back({mAddr[5:1], value[3:0], mLatch});
        end else begin
          refMem[mAddr] = value;
          expVram.push_back({mAddr, value});
        end
        mAddr = mAddr + 14'd1;
      end
      OP_DR: begin
        mSecond = 1'b0;
        modelPrefetch();
      end
      default: begin
        mSecond = 1'b0;
        mF = 1'b0; mOvr = 1'b0; mCol = 1'b0;
      end
    endcase
    repeat (gap) @(posedge clk);
  endtask

  // One-clock status set pulses {vblank, overflow, collision}
  task automatic pulseFlags(input logic [2:0] which);
    settle(6);
    @(posedge clk); #1;
    vblank_set = which[2]; spr_ovr_set = which[1]; spr_col_set = which[0];
    @(posedge clk); #1;
    vblank_set = 1'b0; spr_ovr_set = 1'b0; spr_col_set = 1'b0;
    mF = mF | which[2]; mOvr = mOvr | which[1]; mCol = mCol | which[0];
    settle(2);
  endtask

  // Control read whose clear lands in the same clock as a vblank set pulse
  task automatic sameClockClear();
    settle(6);
    @(posedge clk); #1;
    control_rd = 1'b1;
    repeat (3) @(posedge clk);
    #1 control_rd = 1'b0;
    @(posedge clk); #1;
    vblank_set = 1'b1;
    @(posedge clk); #1;
    vblank_set = 1'b0;
    mSecond = 1'b0;
    mF = 1'b1; mOvr = 1'b0; mCol = 1'b0;
  endtask

  // Let everything finish, then compare all predicted pulses and the outputs
  task automatic drainCheck();
    logic [21:0] ov;
    logic [16:0] oc;
    logic [11:0] orr;
    settle(8);
    @(negedge clk);
    while (expVram.size() > 0) begin
      ov = (obsVram.size() > 0) ? obsVram.pop_front() : 22'bx;
      checkOutput("vram_write", ov, expVram.pop_front());
    end
    checkOutput("vram_extra", obsVram.size(), 0);
    while (expCram.size() > 0) begin
      oc = (obsCram.size() > 0) ? obsCram.pop_front() : 17'bx;
      checkOutput("cram_write", oc, expCram.pop_front());
    end
    checkOutput("cram_extra", obsCram.size(), 0);
    while (expReg.size() > 0) begin
      orr = (obsReg.size() > 0) ? obsReg.pop_front() : 12'bx;
      checkOutput("reg_write", orr, expReg.pop_front());
    end
    checkOutput("reg_extra", obsReg.size(), 0);
    obsVram.delete(); obsCram.delete(); obsReg.delete();
    checkOutput("data_o", data_o, mBuffer);
    checkOutput("control_o", control_o, {mF, mOvr, mCol, 5'b00000});
    checkOutput("irq_n", irq_n, !(mF && frame_ie));
    checkOutput("addr", vram_addr, mAddr);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    control_wr = 1'b0; control_rd = 1'b0; data_wr = 1'b0; data_rd = 1'b0;
    control_i = 8'h00; data_i = 8'h00;
    vblank_set = 1'b0; spr_ovr_set = 1'b0; spr_col_set = 1'b0; frame_ie = 1'b0;
    for (int i = 0; i < 16384; i++) begin
      vram[i]   = 8'($urandom);
      refMem[i] = vram[i];
    end
    modelReset();

    // Reset state
    #22;
    checkOutput("rst_control_o", control_o, 8'h00);
    checkOutput("rst_data_o", data_o, 8'h00);
    checkOutput("rst_irq_n", irq_n, 1'b1);
    checkOutput("rst_vram_we", vram_we, 1'b0);
    checkOutput("rst_cram_we", cram_we, 1'b0);
    checkOutput("rst_reg_we", reg_we, 1'b0);
    checkOutput("rst_addr", vram_addr, 14'h0000);
    @(posedge clk); #1 rst = 1'b0;
    settle(2);

    // VRAM writes with auto-increment
    applyStimulus(OP_CW, 8'h00, 3);
    applyStimulus(OP_CW, 8'h40, 3);
    applyStimulus(OP_DW, 8'hAA, 3);
    applyStimulus(OP_DW, 8'hBB, 3);
    drainCheck();
    checkOutput("tp1_addr", vram_addr, 14'h0002);

    // Read setup with prefetch, then two data reads
    vram[16'h10] = 8'h5A; refMem[16'h10] = 8'h5A;
    vram[16'h11] = 8'hC3; refMem[16'h11] = 8'hC3;
    applyStimulus(OP_CW, 8'h10, 3);
    applyStimulus(OP_CW, 8'h00, 3);
    drainCheck();
    checkOutput("tp2_prefetch", data_o, 8'h5A);
    applyStimulus(OP_DR, 8'h00, 3);
    drainCheck();
    checkOutput("tp2_second", data_o, 8'hC3);
    checkOutput("tp2_addr", vram_addr, 14'h0012);
    applyStimulus(OP_DR, 8'h00, 3);
    drainCheck();

    // Register write
    applyStimulus(OP_CW, 8'h26, 3);
    applyStimulus(OP_CW, 8'h81, 3);
    drainCheck();

    // CRAM byte pair
    applyStimulus(OP_CW, 8'h04, 3);
    applyStimulus(OP_CW, 8'hC0, 3);
    applyStimulus(OP_DW, 8'h3F, 3);
    drainCheck();
    applyStimulus(OP_DW, 8'h0A, 3);
    drainCheck();

    // Frame interrupt, read-clear, and set winning over clear
    frame_ie = 1'b1;
    pulseFlags(3'b100);
    settle(2);
    checkOutput("tp5_irq_low", irq_n, 1'b0);
    checkOutput("tp5_status", control_o, 8'h80);
    applyStimulus(OP_CR, 8'h00, 3);
    settle(2);
    checkOutput("tp5_cleared", control_o, 8'h00);
    checkOutput("tp5_irq_high", irq_n, 1'b1);
    sameClockClear();
    drainCheck();
    checkOutput("tp5_set_wins", control_o[7], 1'b1);

    // Control read resets the byte toggle; address wrap
    applyStimulus(OP_CW, 8'h12, 3);
    applyStimulus(OP_CR, 8'h00, 3);
    applyStimulus(OP_CW, 8'h34, 3);
    applyStimulus(OP_CW, 8'h40, 3);
    applyStimulus(OP_DW, 8'h77, 3);
    drainCheck();
    checkOutput("tp6_toggle", vram_addr, 14'h0035);
    applyStimulus(OP_CW, 8'hFF, 3);
    applyStimulus(OP_CW, 8'h7F, 3);
    applyStimulus(OP_DW, 8'h11, 3);
    applyStimulus(OP_DW, 8'h22, 3);
    drainCheck();
    checkOutput("tp6_wrap", vram_addr, 14'h0001);

    // Randomized traffic with short gaps so events queue behind prefetches
    for (int blk = 0; blk < 12; blk++) begin
      frame_ie = 1'($urandom);
      settle(4);
      for (int n = 0; n < 24; n++) begin
        r = $urandom_range(0, 9);
        if (r <= 2)      applyStimulus(OP_CW, 8'($urandom), $urandom_range(1, 3));
        else if (r <= 5) applyStimulus(OP_DW, 8'($urandom), $urandom_range(1, 3));
        else if (r <= 7) applyStimulus(OP_DR, 8'h00, $urandom_range(1, 3));
        else if (r == 8) applyStimulus(OP_CR, 8'h00, $urandom_range(1, 3));
        else             pulseFlags(3'($urandom));
      end
      drainCheck();
    end

    // Reset asserted between a data-write strobe and its execution
    settle(4);
    obsVram.delete(); obsCram.delete(); obsReg.delete();
    @(posedge clk); #1;
    data_i = 8'h99; data_wr = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("midrst_vram_we", vram_we, 1'b0);
    checkOutput("midrst_irq_n", irq_n, 1'b1);
    data_wr = 1'b0;
    settle(3);
    #1 rst = 1'b0;
    modelReset();
    settle(8);
    @(negedge clk);
    checkOutput("midrst_no_write", obsVram.size(), 0);
    checkOutput("midrst_addr", vram_addr, 14'h0000);
    checkOutput("midrst_data_o", data_o, 8'h00);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
